// File: rtl/digit_scan_display.sv
// -----------------------------------------------------------------------------
// digit_scan_display
//
// Purpose:
//   Time-multiplexes NUM_DIGITS BCD digits (timer seconds/minutes counters)
//   onto one shared 7-segment bus with per-digit anode enables. All digits
//   and decimal-point requests are snapshotted once per scan frame, so a
//   frame never shows a mix of old and new counter values. A blanking gap
//   with every anode off separates consecutive digits to suppress ghosting.
//
// Optional feature (compile-time macro):
//   LEADING_ZERO_BLANK_EN - when defined, leading zero digits (scanning from
//   the most significant digit down) are shown blank: segments and dp off,
//   anode timing unchanged. Digit 0 is never blanked. When undefined, every
//   digit is decoded normally.
//
// Parameters:
//   NUM_DIGITS - digits scanned, index 0 = least significant
//   SCAN_DIV   - clk cycles each digit is lit (>= 1)
//   GAP_CYCLES - clk cycles all anodes are off between digits (0 = no gap)
//   ACTIVE_LOW - 1: seg/dp/anode outputs active-low, 0: active-high
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   en          in   scan enable, 0 blanks the display
//   digits_in   in   packed BCD digits, digit k at [4k+3:4k]
//   dp_mask     in   decimal point request per digit
//   seg_out     out  segments {g,f,e,d,c,b,a} (registered)
//   dp_out      out  decimal point (registered)
//   an_out      out  anode enables, one-hot active when lit (registered)
//   frame_start out  one-cycle pulse on the cycle after a snapshot edge
// -----------------------------------------------------------------------------

// Per-digit BCD to 7-segment decoder with blanking and output polarity.
module dsd_seg_decode #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    logic [6:0] raw;

    // raw is active-high, bit order {g,f,e,d,c,b,a}
    always_comb begin
        raw = 7'b1000000;
        unique case (bcd_i)
            4'd0:    raw = 7'b0111111;
            4'd1:    raw = 7'b0000110;
            4'd2:    raw = 7'b1011011;
            4'd3:    raw = 7'b1001111;
            4'd4:    raw = 7'b1100110;
            4'd5:    raw = 7'b1101101;
            4'd6:    raw = 7'b1111101;
            4'd7:    raw = 7'b0000111;
            4'd8:    raw = 7'b1111111;
            4'd9:    raw = 7'b1101111;
            default: raw = 7'b1000000; // non-BCD codes show a dash
        endcase
        if (blank_i) raw = 7'b0000000;
        seg_o = (ACTIVE_LOW != 0) ? ~raw : raw;
    end
endmodule

module digit_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GAP_CYCLES = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start
);
    localparam int MAXC     = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
    localparam int CW       = $clog2(MAXC + 1);
    localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CW-1:0] SHOW_END = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_LAST);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // Inactive output level; xor-ing an active-high value with it applies
    // the configured polarity.
    localparam logic                  OFF_BIT = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = {7{OFF_BIT}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{OFF_BIT}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP
    } state_e;

    state_e                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]  snap_q, snap_d;
    logic [NUM_DIGITS-1:0]       dps_q, dps_d;
    logic [6:0]                  seg_q, seg_d;
    logic                        dp_q, dp_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic                        fs_q, fs_d;
    logic                        step;

    logic [NUM_DIGITS-1:0]       blank;
    logic [NUM_DIGITS-1:0][6:0]  dec_seg;
    logic [NUM_DIGITS-1:0]       onehot;

    // ---------------------------------------------------------------------
    // Next-state: scan sequencer
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        dps_d   = dps_q;
        fs_d    = 1'b0;
        step    = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    snap_d  = digits_in;
                    dps_d   = dp_mask;
                    fs_d    = 1'b1;
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_END) begin
                        cnt_d = '0;
                        if (GAP_CYCLES > 0) state_d = ST_GAP;
                        else                step    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_END) begin
                        cnt_d = '0;
                        step  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase

            // Advance to the next digit; wrapping past the last digit starts
            // a new frame with a fresh snapshot.
            if (step) begin
                state_d = ST_SHOW;
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    snap_d = digits_in;
                    dps_d  = dp_mask;
                    fs_d   = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Leading-zero blanking, derived from the snapshot the next cycle uses
    // ---------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (snap_d[k] == 4'd0);
            blank[k] = zero_run;
        end
    end
`else
    assign blank = '0;
`endif

    // One decoder per digit lane, fed from the next-cycle snapshot so the
    // registered outputs line up with the registered state.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
        dsd_seg_decode #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_dec (
            .bcd_i   (snap_d[k]),
            .blank_i (blank[k]),
            .seg_o   (dec_seg[k])
        );
    end

    // ---------------------------------------------------------------------
    // Output next-values (outputs are registered alongside the state)
    // ---------------------------------------------------------------------
    always_comb begin
        onehot = NUM_DIGITS'(1) << idx_d;
        seg_d  = SEG_OFF;
        dp_d   = OFF_BIT;
        an_d   = AN_OFF;
        if (state_d == ST_SHOW) begin
            an_d  = onehot ^ AN_OFF;
            seg_d = dec_seg[idx_d];
            dp_d  = blank[idx_d] ? OFF_BIT : (dps_d[idx_d] ^ OFF_BIT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            dps_q   <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= OFF_BIT;
            an_q    <= AN_OFF;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            dps_q   <= dps_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            fs_q    <= fs_d;
        end
    end

    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign an_out      = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_digit_scan_display.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_display
//
// Directed bench for digit_scan_display (NUM_DIGITS=4, SCAN_DIV=4,
// GAP_CYCLES=1, ACTIVE_LOW=1). A frame-position model predicts every
// registered output cycle; predictions are queued when the inputs for an
// edge are driven and popped after the edge. Spot checks against literal
// values from the display's decode table cover the key scenarios.
// -----------------------------------------------------------------------------
module tb_digit_scan_display;
    localparam int N     = 4;
    localparam int S     = 4;
    localparam int G     = 1;
    localparam int FRAME = N * (S + G);

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic [4*N-1:0] digits_in;
    logic [N-1:0]   dp_mask;
    logic [6:0]     seg_out;
    logic           dp_out;
    logic [N-1:0]   an_out;
    logic           frame_start;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         fs;
    } exp_t;

    exp_t sb_q[$];

    // model state: running flag, position in frame, snapshot
    bit           m_run = 1'b0;
    int           m_t   = 0;
    logic [4*N-1:0] m_snap = '0;
    logic [N-1:0]   m_dps  = '0;

    digit_scan_display #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .GAP_CYCLES (G),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .digits_in   (digits_in),
        .dp_mask     (dp_mask),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .an_out      (an_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    // active-high segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_hi(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0: r = 7'h3F;
            4'd1: r = 7'h06;
            4'd2: r = 7'h5B;
            4'd3: r = 7'h4F;
            4'd4: r = 7'h66;
            4'd5: r = 7'h6D;
            4'd6: r = 7'h7D;
            4'd7: r = 7'h07;
            4'd8: r = 7'h7F;
            4'd9: r = 7'h6F;
            default: r = 7'h40;
        endcase
        return r;
    endfunction

    function automatic exp_t model_out(input bit fs);
        exp_t         e;
        int           d;
        int           ph;
        logic [N-1:0] blank;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.an  = '1;
        e.fs  = fs;
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            bit zr;
            zr = 1'b1;
            for (int k = N - 1; k >= 1; k--) begin
                zr       = zr && (m_snap[4*k +: 4] == 4'd0);
                blank[k] = zr;
            end
        end
`endif
        if (m_run) begin
            d  = m_t / (S + G);
            ph = m_t % (S + G);
            if (ph < S) begin
                e.an    = '1;
                e.an[d] = 1'b0;
                if (!blank[d]) begin
                    e.seg = ~seg_hi(m_snap[4*d +: 4]);
                    e.dp  = ~m_dps[d];
                end
            end
        end
        return e;
    endfunction

    // One clock: predict from the inputs about to be sampled, then compare.
    task automatic cyc();
        bit   fs;
        exp_t e;
        exp_t o;
        fs = 1'b0;
        if (reset) begin
            m_run = 1'b0; m_t = 0; m_snap = '0; m_dps = '0;
        end else if (!en) begin
            m_run = 1'b0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_t = 0; m_snap = digits_in; m_dps = dp_mask; fs = 1'b1;
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = 0; m_snap = digits_in; m_dps = dp_mask; fs = 1'b1;
            end
        end
        sb_q.push_back(model_out(fs));
        @(posedge clk);
        #1;
        cyc_no++;
        e = sb_q.pop_front();
        o = {seg_out, dp_out, an_out, frame_start};
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL sb cycle %0d: observed seg=%b dp=%b an=%b fs=%b, expected seg=%b dp=%b an=%b fs=%b",
                   cyc_no, o.seg, o.dp, o.an, o.fs, e.seg, e.dp, e.an, e.fs);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; digits_in = '0; dp_mask = '0;
        cyc(); cyc();
        chk("rst_seg", 32'(seg_out), 32'h7F);
        chk("rst_an",  32'(an_out), 32'hF);
        chk("rst_dp",  32'(dp_out), 32'h1);
        chk("rst_fs",  32'(frame_start), 32'h0);

        reset = 1'b0;
        cyc();
        chk("idle_an", 32'(an_out), 32'hF);

        // first frame 1234
        en = 1'b1; digits_in = 16'h1234;
        cyc();
        chk("f1_fs",   32'(frame_start), 32'h1);
        chk("f1_an0",  32'(an_out), 32'hE);
        chk("f1_seg0", 32'(seg_out), 32'b0011001);
        cyc();
        chk("f1_fs_low", 32'(frame_start), 32'h0);
        repeat (3) cyc();
        chk("f1_gap_an", 32'(an_out), 32'hF);
        cyc();
        chk("f1_an1",  32'(an_out), 32'hD);
        chk("f1_seg1", 32'(seg_out), 32'b0110000);

        // mid-frame change must wait for the wrap
        digits_in = 16'h5678; dp_mask = 4'b0010;
        repeat (14) cyc();
        chk("f1_no_fs_before_wrap", 32'(frame_start), 32'h0);
        cyc();
        chk("f2_fs",   32'(frame_start), 32'h1);
        chk("f2_seg0", 32'(seg_out), 32'b0000000);

        // non-BCD code shows a dash
        digits_in = 16'h56C8; dp_mask = 4'b0000;
        repeat (20) cyc();
        chk("f3_fs", 32'(frame_start), 32'h1);
        repeat (5) cyc();
        chk("dash_an",  32'(an_out), 32'hD);
        chk("dash_seg", 32'(seg_out), 32'b0111111);

        // disable during SHOW(2)
        repeat (5) cyc();
        chk("show2_an", 32'(an_out), 32'hB);
        en = 1'b0;
        cyc();
        chk("dis_an",  32'(an_out), 32'hF);
        chk("dis_seg", 32'(seg_out), 32'h7F);
        cyc();
        en = 1'b1; digits_in = 16'h1234;
        cyc();
        chk("reen_fs",  32'(frame_start), 32'h1);
        chk("reen_an",  32'(an_out), 32'hE);
        chk("reen_seg", 32'(seg_out), 32'b0011001);

        // reset during a gap
        repeat (4) cyc();
        chk("gap_an", 32'(an_out), 32'hF);
        reset = 1'b1;
        cyc();
        chk("mrst_an",  32'(an_out), 32'hF);
        chk("mrst_seg", 32'(seg_out), 32'h7F);
        chk("mrst_fs",  32'(frame_start), 32'h0);
        reset = 1'b0; en = 1'b0;
        repeat (2) cyc();
        chk("post_rst_idle", 32'(an_out), 32'hF);
        en = 1'b1;
        cyc();
        chk("restart_fs", 32'(frame_start), 32'h1);

        // leading zeros
        digits_in = 16'h0045; dp_mask = 4'b1111;
        repeat (20) cyc();
        chk("lz_seg0", 32'(seg_out), 32'b0010010);
        repeat (15) cyc();
        chk("lz_an3", 32'(an_out), 32'h7);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_seg3", 32'(seg_out), 32'h7F);
        chk("lz_dp3",  32'(dp_out), 32'h1);
`else
        chk("lz_seg3", 32'(seg_out), 32'b1000000);
        chk("lz_dp3",  32'(dp_out), 32'h0);
`endif
        digits_in = 16'h0000; dp_mask = 4'b0000;
        repeat (5) cyc();
        chk("zero_an0",  32'(an_out), 32'hE);
        chk("zero_seg0", 32'(seg_out), 32'b1000000);

        // a few random frames, checked by the scoreboard
        for (int f = 0; f < 3; f++) begin
            digits_in = 16'($urandom);
            dp_mask   = 4'($urandom);
            repeat (FRAME) cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/digit_scan_display.md
Name: digit_scan_display

Overview:
- Downstream consumer of the timer digit counters (seconds units/tens, minutes units/tens). Each counter drives one 4-bit BCD digit.
- Snapshots all digits once per scan frame, so no tearing occurs mid-frame.
- Time-multiplexes the digits onto one shared 7-segment bus with per-digit anode enables.
- Inserts a blanking gap between digits to suppress ghosting on the irrigation timer's panel display.

Parameters:
- NUM_DIGITS, 4: digits scanned; index 0 = least significant (seconds units).
- SCAN_DIV, 1000: clk cycles each digit is lit (>=1).
- GAP_CYCLES, 2: clk cycles all anodes are off between digits (0 = no gap).
- ACTIVE_LOW, 1: 1 = segment, anode and dp outputs are active-low; 0 = active-high.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: scan enable; 0 blanks the display.
- digits_in, in, 4*NUM_DIGITS: BCD digits; digit k occupies bits [4k+3:4k], bit order {A,B,C,D} = MSB..LSB.
- dp_mask, in, NUM_DIGITS: decimal point request per digit.
- seg_out, out, 7: segments {g,f,e,d,c,b,a}.
- dp_out, out, 1: decimal point.
- an_out, out, NUM_DIGITS: anode enable, one-hot when lit.
- frame_start, out, 1: one-cycle pulse when a snapshot is taken.

Behaviour:
- All outputs are registered.
  - "Off" means the inactive level for ACTIVE_LOW: all ones when 1, all zeros when 0.
  - Reset: seg_out, dp_out and an_out off; frame_start=0; state IDLE; digit index=0; prescaler=0; snapshot=0.
- States:
  - IDLE: outputs off. If en=1, the next edge latches digits_in/dp_mask into the snapshot, pulses frame_start, and enters SHOW with digit index 0.
  - SHOW(k): an_out lights only bit k; seg_out = decode(snapshot digit k); dp_out = snapshot dp bit k. Lasts exactly SCAN_DIV cycles.
    - Then to GAP if GAP_CYCLES>0.
    - Otherwise directly to the next digit, following the GAP exit rules.
  - GAP: all outputs off for exactly GAP_CYCLES cycles.
    - Exit to SHOW(k+1).
    - When k=NUM_DIGITS-1, wrap to SHOW(0), re-snapshot and pulse frame_start on the same edge.
- Snapshot is updated only at frame start. Changes to digits_in mid-frame are invisible until the next frame.
- en=0 in any state: the next edge goes to IDLE with outputs off, index and prescaler cleared. Re-enable restarts at digit 0 with a fresh snapshot.
- reset mid-scan overrides everything and gives reset values on the next edge.
- Decode (segments on, before polarity):
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=all, 9=abcdfg.
  - Codes 10–15 show "-" (g only).
- Frame period = NUM_DIGITS*(SCAN_DIV+GAP_CYCLES) cycles.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Starting from digit NUM_DIGITS-1 downward, each digit whose snapshot value is 0, with all higher digits also 0, is shown blank.
  - Its segments and dp are off, but the anode still follows the timing, and frame timing is unchanged.
  - Digit 0 is never blanked.
  - Blank decision is made from the snapshot.
- Undefined: every digit is decoded normally, including leading zeros.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4, GAP_CYCLES=1, ACTIVE_LOW=1.
  - Reset, en=1, digits_in=16'h1234 -> frame_start pulses.
  - Then an_out=4'b1110 with seg_out=7'b0011001 ('4') for 4 cycles, then 1 cycle an_out=4'b1111.
  - Then an_out=4'b1101 with '3' (7'b0110000); frame period 20 cycles.
- Change digits_in to 16'h5678 mid-frame -> current frame still shows 1234; frame_start pulses at the wrap; digit 0 then shows '8' (7'b0000000).
- digits_in digit 1 = 4'hC -> seg_out=7'b0111111 ('-') while an_out=4'b1101.
- Deassert en during SHOW(2) -> next cycle an_out=4'b1111 and seg_out=7'h7F. Re-assert -> frame_start pulses and digit 0 is shown.
- reset asserted for 1 cycle mid-GAP -> next cycle all outputs off and frame_start=0. Scan restarts only when en is high after reset drops.
- With LEADING_ZERO_BLANK_EN defined, digits_in=16'h0045 -> digits 3 and 2 have seg_out=7'h7F while their anode is active; digits 1 and 0 show '4' and '5'. digits_in=16'h0000 -> digit 0 shows '0'.
